// File: rtl/cache_ctrl.sv
// Sequencing controller for an 8-set direct-mapped, write-through data cache.
// Define CACHE_STATS_EN to build the load hit/miss counters; otherwise they read as 0.
module cache_ctrl #(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        cache_we_o,
   output logic [2:0]  cache_set_o,
   output logic [26:0] cache_tag_o,
   output logic [31:0] cache_wdata_o,
   input  logic        cache_hit_i,
   input  logic [31:0] cache_rdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic [15:0] hit_cnt_o,
   output logic [15:0] miss_cnt_o
);

   typedef enum logic [1:0] {IDLE, MISS, FILL, STORE} state_t;

   state_t      state;
   logic [2:0]  set_q;
   logic [26:0] tag_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        hit_q;
   logic        unused_addr_bits;

   // The controller has no memory timeout; any other value is a build error.
   if (MEM_TIMEOUT != 0) begin : g_bad_timeout
      $error("cache_ctrl: MEM_TIMEOUT must be 0");
   end

   assign unused_addr_bits = ^addr_i[1:0];

   // Access sequencing; the memory request/write flags are registered so they
   // stay stable until mem_ready_i is seen and drop at once on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         set_q     <= '0;
         tag_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         hit_q     <= 1'b0;
         mem_req_o <= 1'b0;
         mem_we_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i && (we_i || !cache_hit_i)) begin
                  set_q     <= addr_i[4:2];
                  tag_q     <= addr_i[31:5];
                  addr_q    <= {addr_i[31:2], 2'b00};
                  mem_req_o <= 1'b1;
                  if (we_i) begin
                     data_q   <= wdata_i;
                     hit_q    <= cache_hit_i;
                     mem_we_o <= 1'b1;
                     state    <= STORE;
                  end else begin
                     mem_we_o <= 1'b0;
                     state    <= MISS;
                  end
               end
            end
            MISS: begin
               if (mem_ready_i) begin
                  data_q    <= mem_rdata_i;
                  mem_req_o <= 1'b0;
                  state     <= FILL;
               end
            end
            FILL: begin
               state <= IDLE;
            end
            STORE: begin
               if (mem_ready_i) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // In IDLE the lookup follows the live address so a load hit costs no cycle;
   // stall is masked by rst_n so it reads low throughout reset.
   always_comb begin
      stall_o     = 1'b0;
      cache_we_o  = 1'b0;
      cache_set_o = set_q;
      cache_tag_o = tag_q;
      case (state)
         IDLE: begin
            cache_set_o = addr_i[4:2];
            cache_tag_o = addr_i[31:5];
            stall_o     = rst_n & req_i & (we_i | ~cache_hit_i);
         end
         MISS: begin
            stall_o = 1'b1;
         end
         FILL: begin
            stall_o    = 1'b1;
            cache_we_o = 1'b1;
         end
         STORE: begin
            stall_o    = ~mem_ready_i;
            cache_we_o = hit_q & mem_ready_i;
         end
         default: begin
            stall_o = 1'b0;
         end
      endcase
   end

   assign rdata_o       = cache_rdata_i;
   assign cache_wdata_o = data_q;
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = data_q;

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
   logic        refill_q;

   // The hit that completes a just-filled load belongs to its miss, so
   // refill_q keeps it out of the hit count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         refill_q <= 1'b0;
      end else begin
         refill_q <= (state == FILL);
         if (state == IDLE && req_i && !we_i) begin
            if (cache_hit_i) begin
               if (!refill_q) begin
                  hit_cnt <= hit_cnt + 16'd1;
               end
            end else begin
               miss_cnt <= miss_cnt + 16'd1;
            end
         end
      end
   end

   assign hit_cnt_o  = hit_cnt;
   assign miss_cnt_o = miss_cnt;
`else
   assign hit_cnt_o  = 16'h0000;
   assign miss_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl with a cache/memory environment
// and a transaction-level reference model of the cache contents and counters.
module tb_cache_ctrl;

`ifdef CACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        cache_we_o;
   logic [2:0]  cache_set_o;
   logic [26:0] cache_tag_o;
   logic [31:0] cache_wdata_o;
   logic        cache_hit_i;
   logic [31:0] cache_rdata_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ready_i;
   logic [31:0] mem_rdata_i;
   logic [15:0] hit_cnt_o;
   logic [15:0] miss_cnt_o;

   int compared = 0;
   int mismatched = 0;

   // Environment cache storage, written only by the DUT.
   logic [7:0]  cvalid = 8'h00;
   logic [26:0] ctag [8];
   logic [31:0] cdata [8];
   int          wrCount = 0;
   logic [2:0]  lastWrSet = '0;
   logic [26:0] lastWrTag = '0;

   // Reference model state.
   logic        rvalid [8];
   logic [26:0] rtag [8];
   logic [31:0] rdat [8];
   logic [15:0] refHits;
   logic [15:0] refMisses;
   logic [31:0] mem [logic [31:0]];

   cache_ctrl #(.MEM_TIMEOUT(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
      .cache_we_o(cache_we_o), .cache_set_o(cache_set_o), .cache_tag_o(cache_tag_o),
      .cache_wdata_o(cache_wdata_o), .cache_hit_i(cache_hit_i),
      .cache_rdata_i(cache_rdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
      .mem_rdata_i(mem_rdata_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   assign cache_hit_i   = cvalid[cache_set_o] && (ctag[cache_set_o] == cache_tag_o);
   assign cache_rdata_i = cdata[cache_set_o];

   // The cache array captures whatever the controller writes.
   always @(posedge clk) begin
      if (cache_we_o) begin
         cvalid[cache_set_o] <= 1'b1;
         ctag[cache_set_o]   <= cache_tag_o;
         cdata[cache_set_o]  <= cache_wdata_o;
         lastWrSet           <= cache_set_o;
         lastWrTag           <= cache_tag_o;
         wrCount             <= wrCount + 1;
      end
   end

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_1234;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_hits"}, 64'(hit_cnt_o), STATS ? 64'(refHits) : 64'd0);
      checkOutput({tag, "_misses"}, 64'(miss_cnt_o), STATS ? 64'(refMisses) : 64'd0);
   endtask

   // One complete CPU access; memory answers on the (lat+1)-th request cycle.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input int lat);
      logic [2:0]  s;
      logic [26:0] t;
      logic [31:0] wa, memv, rd, expRd;
      logic        hit, done;
      int          stalls, reqs, wrBefore, expStall, expReqs, expWr;
      s = a[4:2];
      t = a[31:5];
      wa = {a[31:2], 2'b00};
      memv = memRead(wa);
      hit = rvalid[s] && (rtag[s] == t);
      wrBefore = wrCount;
      req_i = 1'b1;
      we_i = w;
      addr_i = a;
      wdata_i = d;
      stalls = 0;
      reqs = 0;
      done = 1'b0;
      rd = '0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (mem_req_o) begin
            reqs++;
            checkOutput("mem_addr", 64'(mem_addr_o), 64'(wa));
            checkOutput("mem_we", 64'(mem_we_o), 64'(w));
            if (w) checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(d));
            if (reqs == lat + 1) begin
               mem_ready_i = 1'b1;
               mem_rdata_i = memv;
               if (mem_we_o) mem[wa] = mem_wdata_o;
            end
         end
         #1;
         if (stall_o) stalls++;
         else begin
            done = 1'b1;
            rd = rdata_o;
         end
         @(posedge clk);
         #1;
         mem_ready_i = 1'b0;
         mem_rdata_i = $urandom;
      end
      if (!done) checkOutput("timeout", 64'd1, 64'd0);
      expRd = '0;
      if (!w) begin
         if (hit) begin
            expStall = 0; expReqs = 0; expWr = 0;
            expRd = rdat[s];
            refHits++;
         end else begin
            expStall = lat + 3; expReqs = lat + 1; expWr = 1;
            expRd = memv;
            refMisses++;
            rvalid[s] = 1'b1; rtag[s] = t; rdat[s] = memv;
         end
         checkOutput("rdata", 64'(rd), 64'(expRd));
      end else begin
         expStall = lat + 1; expReqs = lat + 1;
         expWr = hit ? 1 : 0;
         if (hit) rdat[s] = d;
      end
      checkOutput("stall_cycles", 64'(stalls), 64'(expStall));
      checkOutput("mem_req_cycles", 64'(reqs), 64'(expReqs));
      checkOutput("cache_writes", 64'(wrCount - wrBefore), 64'(expWr));
      checkOutput("cache_line", {4'h0, cvalid[s], ctag[s], cdata[s]},
                  {4'h0, rvalid[s], rtag[s], rdat[s]});
      checkCounters("cnt");
   endtask

   task automatic idleCycle();
      req_i = 1'b0;
      @(negedge clk);
      checkOutput("idle_stall", 64'(stall_o), 64'd0);
      checkOutput("idle_mem_req", 64'(mem_req_o), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      int          wrBefore;
      for (int i = 0; i < 8; i++) begin
         rvalid[i] = 1'b0; rtag[i] = '0; rdat[i] = '0;
      end
      refHits = '0;
      refMisses = '0;
      mem[32'h0000_0040] = 32'hDEAD_BEEF;
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      wdata_i = '0;
      we_i = 1'b0;
      addr_i = 32'h0000_0040;
      req_i = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_stall", 64'(stall_o), 64'd0);
      checkOutput("rst_mem_req", 64'(mem_req_o), 64'd0);
      checkOutput("rst_mem_we", 64'(mem_we_o), 64'd0);
      checkOutput("rst_cache_we", 64'(cache_we_o), 64'd0);
      checkOutput("rst_mem_addr", 64'(mem_addr_o), 64'd0);
      checkCounters("rst");
      req_i = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 2);
      checkOutput("fill_set", 64'(lastWrSet), 64'd0);
      checkOutput("fill_tag", 64'(lastWrTag), 64'h2);
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 0);
      applyStimulus(1'b1, 32'h0000_0040, 32'h1234_5678, 1);
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 0);
      applyStimulus(1'b1, 32'h0000_0060, 32'hCAFE_F00D, 2);
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 0);
      idleCycle();

      // Reset while a miss waits on a stalled memory.
      wrBefore = wrCount;
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0104;
      repeat (3) @(negedge clk);
      checkOutput("pre_rst_mem_req", 64'(mem_req_o), 64'd1);
      checkOutput("pre_rst_stall", 64'(stall_o), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_mem_req", 64'(mem_req_o), 64'd0);
      checkOutput("midrst_stall", 64'(stall_o), 64'd0);
      refHits = '0;
      refMisses = '0;
      @(posedge clk);
      #1;
      req_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midrst_no_write", 64'(wrCount - wrBefore), 64'd0);
      checkOutput("midrst_line", {4'h0, cvalid[1], ctag[1], cdata[1]},
                  {4'h0, rvalid[1], rtag[1], rdat[1]});
      checkCounters("midrst");

      for (int i = 0; i < 300; i++) begin
         a = ($urandom & 32'h0000_01FC) | (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'h0);
         a[1:0] = 2'($urandom);
         applyStimulus(($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) idleCycle();
      end

`ifdef CACHE_STATS_EN
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0040;
      repeat (65536) @(posedge clk);
      #1;
      req_i = 1'b0;
      @(negedge clk);
      checkOutput("hit_wrap", 64'(hit_cnt_o), 64'(16'(32'(refHits) + 32'd65536)));
      checkOutput("miss_after_wrap", 64'(miss_cnt_o), 64'(refMisses));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
